// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce eight slow inputs, then hold the last
// one-hot code of each 4-bit group so downstream decoders never see illegal values.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sensor_raw,
    input  logic [3:0] op_raw,
    output logic [3:0] sensor_clean,
    output logic [3:0] op_clean,
    output logic       sensor_valid,
    output logic       op_valid,
    output logic [3:0] sensor_held,
    output logic [3:0] op_held,
    output logic       change_strobe
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [3:0]       s_held_q, s_held_d, o_held_q, o_held_d;
    logic             strobe_q, strobe_d;
    logic             s_upd, o_upd;

    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i]   = (sync2_q[i] == clean_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
            clean_d[i] = (sync2_q[i] != clean_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : clean_q[i];
        end
        sensor_valid = $countones(clean_q[3:0]) == 1;
        op_valid     = $countones(clean_q[7:4]) == 1;
        s_upd        = sensor_valid && clean_q[3:0] != s_held_q;
        o_upd        = op_valid && clean_q[7:4] != o_held_q;
        s_held_d     = s_upd ? clean_q[3:0] : s_held_q;
        o_held_d     = o_upd ? clean_q[7:4] : o_held_q;
        strobe_d     = s_upd || o_upd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            clean_q  <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            s_held_q <= 4'b0001;
            o_held_q <= 4'b0001;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= {op_raw, sensor_raw};
            sync2_q  <= sync1_q;
            clean_q  <= clean_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            s_held_q <= s_held_d;
            o_held_q <= o_held_d;
            strobe_q <= strobe_d;
        end
    end

    assign sensor_clean  = clean_q[3:0];
    assign op_clean      = clean_q[7:4];
    assign sensor_held   = s_held_q;
    assign op_held       = o_held_q;
    assign change_strobe = strobe_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: random and directed stimulus against a window-based
// behavioural model, plus literal checks of the documented timing points.
module tb_input_conditioner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sensor_raw = '0, op_raw = '0;
    logic [3:0] sensor_clean, op_clean, sensor_held, op_held;
    logic       sensor_valid, op_valid, change_strobe;

    int checks = 0;
    int failures = 0;
    int stb_total = 0;
    int s0;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .op_raw(op_raw),
        .sensor_clean(sensor_clean), .op_clean(op_clean),
        .sensor_valid(sensor_valid), .op_valid(op_valid),
        .sensor_held(sensor_held), .op_held(op_held), .change_strobe(change_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [3:0] v);
        return v inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a clean bit flips once its last D synchronised samples all disagree with it.
    logic [7:0] m_s1, m_s2, m_clean;
    logic [3:0] m_sh, m_oh;
    logic       m_stb;
    bit         win [8][$];

    always @(posedge clk or negedge reset) begin
        logic [7:0] c;
        int n;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0;
            m_sh = 4'b0001; m_oh = 4'b0001; m_stb = 1'b0;
            for (int i = 0; i < 8; i++) win[i] = {};
        end else begin
            c = m_clean;
            m_stb = 1'b0;
            if (legal(c[3:0]) && c[3:0] != m_sh) begin m_sh = c[3:0]; m_stb = 1'b1; end
            if (legal(c[7:4]) && c[7:4] != m_oh) begin m_oh = c[7:4]; m_stb = 1'b1; end
            for (int i = 0; i < 8; i++) begin
                win[i].push_back(m_s2[i]);
                if (win[i].size() > D) void'(win[i].pop_front());
                n = 0;
                foreach (win[i][k]) if (win[i][k] != c[i]) n++;
                if (n == D) m_clean[i] = ~c[i];
            end
            m_s2 = m_s1;
            m_s1 = {op_raw, sensor_raw};
        end
    end

    always @(negedge clk) begin
        chk("sensor_clean", sensor_clean, m_clean[3:0]);
        chk("op_clean", op_clean, m_clean[7:4]);
        chk("sensor_valid", {3'b0, sensor_valid}, {3'b0, legal(m_clean[3:0])});
        chk("op_valid", {3'b0, op_valid}, {3'b0, legal(m_clean[7:4])});
        chk("sensor_held", sensor_held, m_sh);
        chk("op_held", op_held, m_oh);
        chk("change_strobe", {3'b0, change_strobe}, {3'b0, m_stb});
        if (change_strobe) stb_total++;
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_held", sensor_held, 4'b0001);
        chk("rst_clean", sensor_clean, 4'b0000);
        @(negedge clk) reset = 1'b1;
        sensor_raw = 4'b0100;
        repeat (8) @(negedge clk);
        chk("pre_arst_held", sensor_held, 4'b0100);
        sensor_raw = 4'b1000;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_held", sensor_held, 4'b0001);
        chk("arst_op_held", op_held, 4'b0001);
        chk("arst_clean", sensor_clean, 4'b0000);
        chk("arst_strobe", {3'b0, change_strobe}, 4'b0000);
        chk("arst_valid", {3'b0, sensor_valid}, 4'b0000);
        sensor_raw = 4'b0010;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_arst_clean", sensor_clean, 4'b0000);
        @(negedge clk) sensor_raw = 4'b0000;
        repeat (10) @(negedge clk);
        // clean step
        sensor_raw = 4'b0100;
        repeat (5) @(posedge clk);
        #1 chk("step_e5_clean", sensor_clean, 4'b0000);
        @(posedge clk) #1;
        chk("step_e6_clean", sensor_clean, 4'b0100);
        chk("step_e6_valid", {3'b0, sensor_valid}, 4'b0001);
        chk("step_e6_held", sensor_held, 4'b0001);
        @(posedge clk) #1;
        chk("step_e7_held", sensor_held, 4'b0100);
        chk("step_e7_strobe", {3'b0, change_strobe}, 4'b0001);
        @(posedge clk) #1;
        chk("step_e8_strobe", {3'b0, change_strobe}, 4'b0000);
        // bounce reject
        @(negedge clk) s0 = stb_total;
        repeat (5) begin
            op_raw = 4'b0010;
            repeat (3) @(negedge clk);
            op_raw = 4'b0000;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("bounce_clean", op_clean, 4'b0000);
        chk("bounce_held", op_held, 4'b0001);
        chk("bounce_strobes", 4'(stb_total - s0), 4'd0);
        // illegal code, then legal
        s0 = stb_total;
        sensor_raw = 4'b0110;
        repeat (10) @(negedge clk);
        chk("illegal_clean", sensor_clean, 4'b0110);
        chk("illegal_valid", {3'b0, sensor_valid}, 4'b0000);
        chk("illegal_held", sensor_held, 4'b0100);
        chk("illegal_strobes", 4'(stb_total - s0), 4'd0);
        sensor_raw = 4'b0010;
        repeat (10) @(negedge clk);
        chk("legal_held", sensor_held, 4'b0010);
        chk("legal_strobes", 4'(stb_total - s0), 4'd1);
        // same code as reset value
        s0 = stb_total;
        op_raw = 4'b0001;
        repeat (10) @(negedge clk);
        chk("same_valid", {3'b0, op_valid}, 4'b0001);
        chk("same_held", op_held, 4'b0001);
        chk("same_strobes", 4'(stb_total - s0), 4'd0);
        // simultaneous update
        s0 = stb_total;
        sensor_raw = 4'b1000;
        op_raw = 4'b0100;
        repeat (6) @(posedge clk);
        #1;
        chk("sim_e6_sheld", sensor_held, 4'b0010);
        chk("sim_e6_oheld", op_held, 4'b0001);
        @(posedge clk) #1;
        chk("sim_e7_sheld", sensor_held, 4'b1000);
        chk("sim_e7_oheld", op_held, 4'b0100);
        chk("sim_e7_strobe", {3'b0, change_strobe}, 4'b0001);
        @(posedge clk) #1;
        chk("sim_e8_strobe", {3'b0, change_strobe}, 4'b0000);
        repeat (4) @(negedge clk);
        chk("sim_strobes", 4'(stb_total - s0), 4'd1);
        // randomized segments
        for (int seg = 0; seg < 500; seg++) begin
            if ($urandom_range(0, 2) == 0) begin
                sensor_raw = 4'($urandom);
                op_raw = 4'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                sensor_raw = 4'(1 << $urandom_range(0, 3));
                op_raw = 4'(1 << $urandom_range(0, 3));
            end else begin
                sensor_raw[$urandom_range(0, 3)] ^= 1'b1;
            end
            if ($urandom_range(0, 59) == 0) begin
                #3 reset = 1'b0;
                @(negedge clk) reset = 1'b1;
            end
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
